// File: rtl/muldiv_sequencer.sv
// Signed 32x32 multiply / 32/32 divide sequencer with one shared 64-bit shift register (optional MULDIV_DIVZERO_FASTEXIT_EN).
// Latency: 33 cycles from accepted start to the done/FINISH cycle (1 cycle for a zero divisor when MULDIV_DIVZERO_FASTEXIT_EN is defined).
// Backpressure: starts are sampled only in IDLE; starts seen while busy are dropped, never queued.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        hi_write,
    output logic        lo_write,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MULDIV_DIVZERO_FASTEXIT_EN
    localparam bit FAST_DZ = 1'b1;
`else
    localparam bit FAST_DZ = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        dz_q, dz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        hi_write_q, hi_write_d;
    logic        lo_write_q, lo_write_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [32:0] mult_sum;
    logic [63:0] mult_next;
    logic [63:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] iter_next;
    logic [63:0] prod_signed;
    logic [31:0] quot_signed;
    logic [31:0] rem_signed;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // One iteration of each algorithm; the unused one is simply discarded.
    always_comb begin
        mult_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
        mult_next = {mult_sum, acc_q[31:1]};
        div_shift = {acc_q[62:0], 1'b0};
        div_diff  = {1'b0, div_shift[63:32]} - {1'b0, b_mag_q};
        div_next  = div_diff[32] ? div_shift : {div_diff[31:0], div_shift[31:1], 1'b1};
        iter_next = (state_q == DIV) ? div_next : mult_next;
    end

    // Sign correction is applied to the final iteration result on its way into hi/lo.
    always_comb begin
        prod_signed = neg_q ? (~iter_next + 64'd1) : iter_next;
        quot_signed = neg_q ? (~iter_next[31:0] + 32'd1) : iter_next[31:0];
        rem_signed  = rem_neg_q ? (~iter_next[63:32] + 32'd1) : iter_next[63:32];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_mag_d    = b_mag_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_write_d = 1'b0;
        lo_write_d = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start_mult || start_div) begin
                    acc_d     = {32'd0, mag32(op_a)};
                    b_mag_d   = mag32(op_b);
                    neg_d     = op_a[31] ^ op_b[31];
                    rem_neg_d = op_a[31];
                    dz_d      = !start_mult && (op_b == 32'd0);
                    cnt_d     = 6'd0;
                    busy_d    = 1'b1;
                    state_d   = start_mult ? MULT : DIV;
                    if (FAST_DZ && !start_mult && (op_b == 32'd0)) begin
                        state_d    = FINISH;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end
                end
            end
            MULT, DIV: begin
                acc_d = iter_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FINISH;
                    cnt_d   = 6'd0;
                    done_d  = 1'b1;
                    if (dz_q) begin
                        div_zero_d = 1'b1;
                    end else begin
                        hi_write_d = 1'b1;
                        lo_write_d = 1'b1;
                        if (state_q == DIV) begin
                            hi_d = rem_signed;
                            lo_d = quot_signed;
                        end else begin
                            hi_d = prod_signed[63:32];
                            lo_d = prod_signed[31:0];
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            acc_q      <= 64'd0;
            b_mag_q    <= 32'd0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_mag_q    <= b_mag_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_write_q <= hi_write_d;
            lo_write_q <= lo_write_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi_write = hi_write_q;
    assign lo_write = lo_write_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table of hand-computed vectors, random vectors checked by a 64-bit model, and
// hand sequences for reset-abort and start-while-busy; results flow through a scoreboard queue.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] op_a, op_b;
    logic        busy, done, hi_write, lo_write, div_zero;
    logic [31:0] hi, lo;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi_write(hi_write),
        .lo_write(lo_write), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_DIVZERO_FASTEXIT_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    typedef struct {
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } exp_t;

    exp_t        scb[$];
    vec_t        tbl[12];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ph, input logic [31:0] pl);
        exp_t               e;
        logic signed [63:0] sa, sbv, p, q, r;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        if (m) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (b == 32'd0) begin
            e.hi = ph;
            e.lo = pl;
            e.dz = 1'b1;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int poke);
        int   lat;
        exp_t got;
        lat = (!m && d && b == 32'd0) ? DZ_LAT : 33;
        scb.push_back(e);
        @(negedge clk);
        start_mult = m; start_div = d; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0; op_a = $urandom; op_b = $urandom;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start_div = (cyc == poke);
            if (cyc == poke) op_b = 32'd0;
            chk("busy", {63'd0, busy}, {63'd0, cyc <= lat});
            chk("done", {63'd0, done}, {63'd0, cyc == lat});
            chk("div_zero", {63'd0, div_zero}, {63'd0, (cyc == lat) && e.dz});
            chk("hi_write", {63'd0, hi_write}, {63'd0, (cyc == lat) && !e.dz});
            chk("lo_write", {63'd0, lo_write}, {63'd0, (cyc == lat) && !e.dz});
            if (done) begin
                if (scb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL extra_done: got done=1, want no pending result (t=%0t)", $time);
                end else begin
                    got = scb.pop_front();
                    chk("hi", {32'd0, hi}, {32'd0, got.hi});
                    chk("lo", {32'd0, lo}, {32'd0, got.lo});
                    cur_hi = got.hi;
                    cur_lo = got.lo;
                end
            end else begin
                chk("hi_hold", {32'd0, hi}, {32'd0, cur_hi});
                chk("lo_hold", {32'd0, lo}, {32'd0, cur_lo});
            end
        end
        start_div = 1'b0;
        if (scb.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL no_done: got %0d pending results, want 0", scb.size());
            scb.delete();
        end
    endtask

    initial begin
        exp_t        e;
        bit          rm;
        logic [31:0] ra, rb;

        tbl[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'd5,          32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'd100,        32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'd7,          32'd7,        32'h00000000, 32'h00000001, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h7FFFFFFF,   32'd1,        32'h00000000, 32'h7FFFFFFF, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'd0,        32'h00000000, 32'h7FFFFFFF, 1'b1};

        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; op_a = 32'd0; op_b = 32'd0;
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_writes", {62'd0, hi_write, lo_write}, 64'd0);
        chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dz = tbl[i].dz;
            run_op(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, e, 0);
        end

        for (int i = 0; i < 8; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            e = model(rm, ra, rb, cur_hi, cur_lo);
            run_op(rm, !rm, ra, rb, e, 0);
        end

        // start_div pulse (zero divisor) mid-multiply must be dropped
        e.hi = 32'd0; e.lo = 32'd15; e.dz = 1'b0;
        run_op(1'b1, 1'b0, 32'd3, 32'd5, e, 5);

        // reset at iteration 10 of a multiply
        @(negedge clk);
        start_mult = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        cur_hi = 32'd0; cur_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            chk("post_abort_done", {63'd0, done}, 64'd0);
            chk("post_abort_strobes", {61'd0, busy, hi_write, lo_write}, 64'd0);
        end

        e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFEB; e.dz = 1'b0;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, e, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
